mem_sram_sequencer: RTL and testbench
=====================================

# mem_sram_sequencer

Multi-cycle controller between the pipeline MEM stage and an external 16-bit asynchronous SRAM. Each 32-bit load or store from the EXE/MEM register becomes two sequenced half-word SRAM transactions, low half first. While an access is in flight, `ready` is held low. The top level ORs `~ready` into the freeze of every pipeline register and the PC, so the whole pipeline stalls until the access completes.

## Interface
- `ADDR_BASE`, default 1024: byte address of SRAM word 0; pipeline addresses are offset by this value.
- `HOLD`, default 2: cycles per half-word phase; legal minimum is 2.
- `clk` in 1: pipeline clock.
- `rst` in 1: reset; asynchronous, active-high.
- `mem_r_en` in 1: load request from the EXE/MEM register.
- `mem_w_en` in 1: store request from the EXE/MEM register.
- `address` in 32: byte address (ALU result).
- `wdata` in 32: store value.
- `rdata` out 32: load result, passed to the MEM/WB register.
- `ready` out 1: high means no access is pending or the current access completes this cycle.
- `sram_addr` out 18: SRAM half-word address.
- `sram_dq` inout 16: SRAM data bus.
- `sram_we_n` out 1: SRAM write enable, active-low.
- `sram_oe_n` out 1: SRAM output enable, active-low.

## Operation
- **States:** IDLE, LOW, HIGH, DONE. A phase counter `cnt` (width clog2(HOLD)) runs within LOW and HIGH.
- **IDLE:**
  - If `mem_w_en | mem_r_en`: latch the operation, `address`, and `wdata`; clear `cnt`; go to LOW.
  - If both enables are high, write has priority.
- **LOW / HIGH:**
  - Each phase lasts exactly HOLD cycles; `cnt` counts 0..HOLD-1.
  - LOW advances to HIGH when `cnt == HOLD-1`.
  - HIGH advances to DONE when `cnt == HOLD-1`.
- **DONE:** lasts one cycle, then unconditionally returns to IDLE. The enables are not re-sampled in DONE, because the pipeline advances on the edge that ends DONE.
- **Address mapping:**
  - word = (latched address − ADDR_BASE) >> 2, computed at 32 bits.
  - `sram_addr` = {word[16:0], 0} in LOW and {word[16:0], 1} in HIGH.
  - Upper bits and the two LSBs of the address are ignored.
- **Write:**
  - `sram_dq` drives latched wdata[15:0] in LOW and wdata[31:16] in HIGH.
  - `sram_we_n` = 0 for every cycle of a phase except the last (`cnt == HOLD-1`), which provides data hold.
  - `sram_oe_n` = 1 throughout.
- **Read:**
  - `sram_oe_n` = 0 throughout LOW and HIGH; `sram_dq` is high-Z.
  - `rdata[15:0]` is captured from `sram_dq` on the last LOW cycle; `rdata[31:16]` on the last HIGH cycle.
  - `rdata` holds its value until the next read overwrites it; writes never change it.
- **Idle bus state:** in IDLE and DONE, `sram_we_n` = `sram_oe_n` = 1, `sram_dq` is high-Z, and `sram_addr` holds its last value.
- **`ready`** (combinational):
  - 1 in IDLE with no request, and in DONE.
  - 0 in IDLE with a request, and in LOW and HIGH.

## Timing
- **Reset values:** state IDLE, `rdata` = 0, `sram_addr` = 0, `sram_we_n` = 1, `sram_oe_n` = 1, `sram_dq` high-Z, `ready` = 1 (no request present).
- **Request timeline** (request first seen in IDLE at cycle 0):
  - LOW occupies cycles 1..HOLD.
  - HIGH occupies cycles HOLD+1..2·HOLD.
  - DONE is cycle 2·HOLD+1, with `ready` = 1.
- **Stall length:** `ready` is low for 2·HOLD+1 cycles (5 at the default HOLD).
- **Read data:** `rdata` is valid in DONE and stays stable afterward for the MEM/WB register to sample.
- **Back-to-back accesses:** the next request is accepted in the IDLE cycle after DONE. Minimum spacing is 2·HOLD+2 cycles.
- **Reset mid-access:** asynchronous return to IDLE. All outputs take their reset values immediately and the bus is released. A partially written word is not completed.
- **Input changes:** after acceptance, changes on `address`, `wdata`, or the enables have no effect until IDLE.
- **Synthesis:** all state and outputs are registered except `ready` and the `sram_dq` tri-state enable, which decode state only.

## Test plan
- **Reset and idle:** assert `rst` with no requests → `ready` = 1, `rdata` = 0, `sram_we_n` = `sram_oe_n` = 1, `sram_dq` = Z. Hold enables low for 10 cycles → no change.
- **Store:** `mem_w_en`, address 1024, `wdata` 0xDEADBEEF, HOLD = 2.
  - `sram_addr` = 0 with `sram_dq` = 0xBEEF in cycles 1–2; `sram_addr` = 1 with `sram_dq` = 0xDEAD in cycles 3–4.
  - `sram_we_n` is low only in cycles 1 and 3.
  - `ready` is 0 in cycles 0–4 and 1 in cycle 5.
- **Load:** SRAM model preloaded with half-words 0xBEEF at 2 and 0xDEAD at 3; `mem_r_en`, address 1028.
  - `sram_addr` steps 2 then 3; `sram_oe_n` is low in cycles 1–4.
  - `rdata` = 0xDEADBEEF in cycle 5.
- **Back-to-back:** store then load to address 1032 with no gap.
  - The second access starts in cycle 6 (the IDLE cycle after DONE).
  - The load returns the stored value.
  - `ready` is high only in cycles 5 and 11.
- **Reset mid-access:** assert `rst` in cycle 3 of a store → immediately `sram_we_n` = 1, `sram_dq` = Z, state IDLE. After release, a new load proceeds normally.
- **Simultaneous enables and HOLD = 3:** both enables high → a write is performed, `ready` is low for 7 cycles, and `rdata` is unchanged.

Source files
------------

// File: rtl/mem_sram_sequencer.sv
// mem_sram_sequencer: splits each 32-bit pipeline load/store into two 16-bit
// asynchronous SRAM accesses (low half first) and stalls the pipeline until done.
module mem_sram_sequencer #(
  parameter logic [31:0] ADDR_BASE = 32'd1024,
  parameter int          HOLD      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [17:0] sram_addr,
  inout  wire  [15:0] sram_dq,
  output logic        sram_we_n,
  output logic        sram_oe_n
);
  localparam int CW = $clog2(HOLD);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, diff;
  logic [17:0]   sram_addr_q, sram_addr_d;
  logic [15:0]   dq_q, dq_d;
  logic          we_n_q, we_n_d, oe_n_q, oe_n_d;
  logic          req, last, busy_d, unused_bits;
  always_comb begin
    req     = mem_w_en | mem_r_en;
    last    = cnt_q == CW'(HOLD - 1);
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = LOW;
        cnt_d   = '0;
        wr_d    = mem_w_en;
        addr_d  = address;
        wdata_d = wdata;
      end
      LOW: begin
        state_d = last ? HIGH : LOW;
        cnt_d   = last ? '0 : cnt_q + CW'(1);
      end
      HIGH: begin
        state_d = last ? DONE : HIGH;
        cnt_d   = last ? '0 : cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
    // Bus outputs are registered, so they are decoded from the next state.
    diff        = addr_d - ADDR_BASE;
    busy_d      = state_d == LOW || state_d == HIGH;
    sram_addr_d = busy_d ? {diff[18:2], state_d == HIGH} : sram_addr_q;
    we_n_d      = !(busy_d && wr_d && cnt_d != CW'(HOLD - 1));
    oe_n_d      = !(busy_d && !wr_d);
    dq_d        = state_d == HIGH ? wdata_d[31:16] : wdata_d[15:0];
    rdata_d     = (!wr_q && last && state_q == LOW)  ? {rdata_q[31:16], sram_dq} :
                  (!wr_q && last && state_q == HIGH) ? {sram_dq, rdata_q[15:0]} : rdata_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
      dq_q        <= '0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
      dq_q        <= dq_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
    end
  end
  assign unused_bits = ^{diff[31:19], diff[1:0]};
  assign ready       = state_q == DONE || (state_q == IDLE && !req);
  assign rdata       = rdata_q;
  assign sram_addr   = sram_addr_q;
  assign sram_we_n   = we_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_dq     = (wr_q && (state_q == LOW || state_q == HIGH)) ? dq_q : 16'hzzzz;
endmodule

// File: tb/tb_mem_sram_sequencer.sv
// tb_mem_sram_sequencer: directed stimulus with a per-cycle expectation queue
// checked by independent negedge monitors for a HOLD=2 and a HOLD=3 instance.
module tb_mem_sram_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic        w2 = 1'b0, r2 = 1'b0, w3 = 1'b0, r3 = 1'b0;
  logic [31:0] address = '0, wdata = '0;
  logic [31:0] rdata2, rdata3;
  logic        ready2, ready3, we2, we3, oe2, oe3;
  logic [17:0] addr2, addr3;
  wire  [15:0] dq2, dq3;
  logic        keep2 = 1'b1, keep3 = 1'b1;
  logic [15:0] mem2 [64] = '{2: 16'hBEEF, 3: 16'hDEAD, default: 16'h0};
  logic [15:0] mem3 [64] = '{default: 16'h0};
  // SRAM models; a bench-side keeper drives a marker value whenever the DUT must have released the bus
  assign dq2 = (!oe2 || keep2) ? (!oe2 ? mem2[addr2[5:0]] : 16'hA5C3) : 16'hzzzz;
  assign dq3 = (!oe3 || keep3) ? (!oe3 ? mem3[addr3[5:0]] : 16'hA5C3) : 16'hzzzz;
  always @(negedge clk) begin
    if (!we2) mem2[addr2[5:0]] <= dq2;
    if (!we3) mem3[addr3[5:0]] <= dq3;
  end
  mem_sram_sequencer #(.ADDR_BASE(32'd1024), .HOLD(2)) u2 (
    .clk(clk), .rst(rst), .mem_r_en(r2), .mem_w_en(w2), .address(address), .wdata(wdata),
    .rdata(rdata2), .ready(ready2), .sram_addr(addr2), .sram_dq(dq2), .sram_we_n(we2), .sram_oe_n(oe2));
  mem_sram_sequencer #(.ADDR_BASE(32'd1024), .HOLD(3)) u3 (
    .clk(clk), .rst(rst), .mem_r_en(r3), .mem_w_en(w3), .address(address), .wdata(wdata),
    .rdata(rdata3), .ready(ready3), .sram_addr(addr3), .sram_dq(dq3), .sram_we_n(we3), .sram_oe_n(oe3));
  typedef struct {
    logic        ready, we_n, oe_n, dq_chk, rd_chk;
    logic [17:0] addr;
    logic [15:0] dq;
    logic [31:0] rdata;
  } exp_t;
  exp_t        q2[$], q3[$];
  exp_t        m2, m3;
  int          checks = 0, failures = 0;
  logic [17:0] ea [2] = '{18'd0, 18'd0};
  logic [31:0] er [2] = '{32'd0, 32'd0};
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic verify(input string d, input exp_t e, input logic rdy, input logic we,
                        input logic oe, input logic [17:0] a, input logic [15:0] dq, input logic [31:0] rd);
    cmp({d, "_ready"}, 32'(rdy), 32'(e.ready));
    cmp({d, "_we_n"}, 32'(we), 32'(e.we_n));
    cmp({d, "_oe_n"}, 32'(oe), 32'(e.oe_n));
    cmp({d, "_sram_addr"}, 32'(a), 32'(e.addr));
    if (e.dq_chk) cmp({d, "_sram_dq"}, 32'(dq), 32'(e.dq));
    if (e.rd_chk) cmp({d, "_rdata"}, rd, e.rdata);
  endtask
  always @(negedge clk) if (q2.size() > 0) begin
    m2 = q2.pop_front();
    verify("u2", m2, ready2, we2, oe2, addr2, dq2, rdata2);
  end
  always @(negedge clk) if (q3.size() > 0) begin
    m3 = q3.pop_front();
    verify("u3", m3, ready3, we3, oe3, addr3, dq3, rdata3);
  end
  function automatic exp_t mk(logic rdy, logic we, logic oe, logic [17:0] a,
                              logic dc, logic [15:0] dq, logic rc, logic [31:0] rd);
    return '{ready: rdy, we_n: we, oe_n: oe, dq_chk: dc, rd_chk: rc, addr: a, dq: dq, rdata: rd};
  endfunction
  task automatic push(input int sel, input exp_t e);
    if (sel == 1) q3.push_back(e);
    else q2.push_back(e);
  endtask
  task automatic idle(input int n, input logic rv);
    repeat (n) begin
      @(posedge clk); #1;
      rst   = rv;
      keep2 = 1'b1;
      keep3 = 1'b1;
      if (rv) begin
        ea[0] = '0; ea[1] = '0; er[0] = '0; er[1] = '0;
      end
      for (int s = 0; s < 2; s++) push(s, mk(1'b1, 1'b1, 1'b1, ea[s], 1'b1, 16'hA5C3, 1'b1, er[s]));
    end
  endtask
  // One access from request cycle 0 through DONE; stop truncates it for the mid-access reset case.
  task automatic access(input int sel, input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd_exp, input int stop);
    int          h;
    logic [16:0] word;
    exp_t        e;
    h    = sel == 1 ? 3 : 2;
    word = 17'((a - 32'd1024) >> 2);
    for (int c = 0; c < 2 * h + 2 && c < stop; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        address = a;
        wdata   = wd;
        if (sel == 1) begin w3 = w; r3 = r; end
        else begin w2 = w; r2 = r; end
      end else if (c == 1) begin
        address = ~a;
        wdata   = ~wd;
        w2 = 1'b0; r2 = 1'b0; w3 = 1'b0; r3 = 1'b0;
      end
      if (c == 0) e = mk(1'b0, 1'b1, 1'b1, ea[sel], 1'b1, 16'hA5C3, 1'b1, er[sel]);
      else if (c <= 2 * h) begin
        int   k  = (c - 1) % h;
        logic hi = c > h;
        ea[sel] = {word, hi};
        e = mk(1'b0, !(w && k != h - 1), w, ea[sel], w, hi ? wd[31:16] : wd[15:0], 1'b0, er[sel]);
      end else begin
        if (!w) er[sel] = rd_exp;
        e = mk(1'b1, 1'b1, 1'b1, ea[sel], 1'b1, 16'hA5C3, 1'b1, er[sel]);
      end
      if (sel == 1) keep3 = c == 0 || c == 2 * h + 1;
      else keep2 = c == 0 || c == 2 * h + 1;
      push(sel, e);
    end
  endtask
  initial begin
    idle(2, 1'b1);
    idle(10, 1'b0);
    access(0, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'h0, 99);
    idle(2, 1'b0);
    access(0, 1'b0, 1'b1, 32'd1028, 32'h0, 32'hDEADBEEF, 99);
    idle(2, 1'b0);
    access(0, 1'b1, 1'b0, 32'd1032, 32'h12345678, 32'h0, 99);
    access(0, 1'b0, 1'b1, 32'd1032, 32'h0, 32'h12345678, 99);
    idle(2, 1'b0);
    access(0, 1'b1, 1'b0, 32'd1040, 32'hCAFEF00D, 32'h0, 3);
    idle(1, 1'b1);
    idle(2, 1'b0);
    access(0, 1'b0, 1'b1, 32'd1040, 32'h0, 32'h0000F00D, 99);
    idle(2, 1'b0);
    access(1, 1'b1, 1'b1, 32'd1028, 32'hA5A55A5A, 32'h0, 99);
    idle(2, 1'b0);
    access(1, 1'b0, 1'b1, 32'd1028, 32'h0, 32'hA5A55A5A, 99);
    idle(2, 1'b0);
    @(posedge clk);
    @(posedge clk);
    if (q2.size() + q3.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0 pending entries", q2.size() + q3.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
